// File: rtl/pipe_ctrl_pkg.sv
// Shared types, constants and control-bundle helpers for pipe_int_ctrl.
// The IRQ_EDGE_DETECT_EN macro selects edge-sensitive interrupt requests.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    ENTER   = 2'd1,
    HANDLER = 2'd2
  } ctrl_state_e;

  localparam logic [2:0] IRS_NONE    = 3'd0;
  localparam int         NUM_IRQ_DEF = 3;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
  } pipe_ctl_t;

  function automatic pipe_ctl_t ctl_idle();
    pipe_ctl_t c;
    c.pc_en      = 1'b1;
    c.ifid_en    = 1'b1;
    c.ifid_flush = 1'b0;
    c.idex_en    = 1'b1;
    c.idex_flush = 1'b0;
    return c;
  endfunction

  function automatic pipe_ctl_t ctl_freeze();
    pipe_ctl_t c;
    c.pc_en      = 1'b0;
    c.ifid_en    = 1'b0;
    c.ifid_flush = 1'b0;
    c.idex_en    = 1'b0;
    c.idex_flush = 1'b0;
    return c;
  endfunction

  // Redirect beats a load-use stall: the stalled instruction is wrong-path anyway.
  function automatic pipe_ctl_t ctl_hazard(input logic branch_taken, input logic load_use);
    pipe_ctl_t c;
    c = ctl_idle();
    if (branch_taken) begin
      c.ifid_flush = 1'b1;
      c.idex_flush = 1'b1;
    end else if (load_use) begin
      c.pc_en      = 1'b0;
      c.ifid_en    = 1'b0;
      c.idex_flush = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder over the pending vector; bit 0 is the highest priority.
module irq_prio_enc
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_IRQ = NUM_IRQ_DEF,
  parameter int IRS_W   = 3
) (
  input  logic [NUM_IRQ-1:0] pending,
  output logic [NUM_IRQ-1:0] winner_oh,
  output logic [IRS_W-1:0]   irs_code,
  output logic               valid
);

  always_comb begin
    winner_oh = '0;
    irs_code  = IRS_W'(IRS_NONE);
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pending[i]) begin
        winner_oh    = '0;
        winner_oh[i] = 1'b1;
        irs_code     = IRS_W'(i + 1);
      end
    end
  end

  assign valid = |pending;

endmodule

// File: rtl/pipe_int_ctrl.sv
// Pipeline enable/flush sequencing and interrupt entry/exit control for the 5-stage core.
// Define IRQ_EDGE_DETECT_EN for rising-edge request detection; default is level-sensitive.
//
// state   | meaning
// RUN     | normal execution, arbitrating pending interrupts
// ENTER   | one-cycle Int_Enter injection into ID/EX, acknowledge winner
// HANDLER | handler executing until uret retires in EX
module pipe_int_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_IRQ = NUM_IRQ_DEF,
  parameter int IRS_W   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_req,
  input  logic               mem_busy,
  input  logic               load_use,
  input  logic               branch_taken,
  input  logic               uret_ex,
  output logic               pc_en,
  output logic               ifid_en,
  output logic               ifid_flush,
  output logic               idex_en,
  output logic               idex_flush,
  output logic               int_enter,
  output logic [IRS_W-1:0]   irs,
  output logic [NUM_IRQ-1:0] int_ack,
  output logic               in_handler
);

  ctrl_state_e        state_q, state_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [IRS_W-1:0]   irs_q, irs_d;
  logic [NUM_IRQ-1:0] req_set;
  logic [NUM_IRQ-1:0] captured_oh;
  logic [NUM_IRQ-1:0] enc_in;
  logic [NUM_IRQ-1:0] enc_oh;
  logic [IRS_W-1:0]   enc_code;
  logic               enc_valid;
  pipe_ctl_t          ctl;

`ifdef IRQ_EDGE_DETECT_EN
  logic [NUM_IRQ-1:0] req_q, req_d;

  always_comb begin
    req_d = irq_req;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) req_q <= '0;
    else     req_q <= req_d;
  end

  assign req_set = irq_req & ~req_q;
`else
  assign req_set = irq_req;
`endif

  always_comb begin
    captured_oh = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      captured_oh[i] = (irs_q == IRS_W'(i + 1));
    end
  end

  // Once a source is captured, a later higher-priority arrival must not steal its acknowledge.
  assign enc_in = (state_q == ENTER) ? (pending_q & captured_oh) : pending_q;

  irq_prio_enc #(
    .NUM_IRQ (NUM_IRQ),
    .IRS_W   (IRS_W)
  ) u_prio_enc (
    .pending   (enc_in),
    .winner_oh (enc_oh),
    .irs_code  (enc_code),
    .valid     (enc_valid)
  );

  always_comb begin
    state_d    = state_q;
    irs_d      = irs_q;
    ctl        = ctl_idle();
    int_enter  = 1'b0;
    int_ack    = '0;
    in_handler = (state_q == HANDLER);

    if (mem_busy) begin
      ctl = ctl_freeze();
    end else begin
      case (state_q)
        RUN: begin
          ctl = ctl_hazard(branch_taken, load_use);
          if (enc_valid && !load_use && !branch_taken) begin
            state_d = ENTER;
            irs_d   = enc_code;
          end
        end
        ENTER: begin
          int_enter      = 1'b1;
          int_ack        = enc_oh;
          ctl.ifid_flush = 1'b1;
          state_d        = HANDLER;
        end
        HANDLER: begin
          ctl = ctl_hazard(branch_taken, load_use);
          if (uret_ex) begin
            state_d = RUN;
            irs_d   = IRS_W'(IRS_NONE);
          end
        end
        default: begin
          state_d = RUN;
          irs_d   = IRS_W'(IRS_NONE);
        end
      endcase
    end
  end

  // A request arriving in the acknowledge cycle survives the clear.
  always_comb begin
    pending_d = (pending_q & ~int_ack) | req_set;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      pending_q <= '0;
      irs_q     <= IRS_W'(IRS_NONE);
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      irs_q     <= irs_d;
    end
  end

  assign pc_en      = ctl.pc_en;
  assign ifid_en    = ctl.ifid_en;
  assign ifid_flush = ctl.ifid_flush;
  assign idex_en    = ctl.idex_en;
  assign idex_flush = ctl.idex_flush;
  assign irs        = irs_q;

`ifndef SYNTHESIS
  a_ack_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(int_ack));
  a_freeze:     assert property (@(posedge clk) disable iff (rst)
                                 mem_busy |-> !(pc_en || ifid_en || idex_en));
  a_enter_src:  assert property (@(posedge clk) disable iff (rst)
                                 int_enter |-> (irs_q != IRS_W'(IRS_NONE)));
`endif

endmodule

// File: tb/tb_pipe_int_ctrl.sv
// Self-checking bench for pipe_int_ctrl: directed scenarios plus randomized traffic against a behavioural model.
`timescale 1ns/1ps
module tb_pipe_int_ctrl;

  localparam int NIRQ = 3;
  localparam int IRSW = 3;
  localparam int VW   = 6 + IRSW + NIRQ + 1;
  localparam int P_PC  = 12;
  localparam int P_FE  = 11;
  localparam int P_FF  = 10;
  localparam int P_DE  = 9;
  localparam int P_DF  = 8;
  localparam int P_ENT = 7;

  logic            clk = 1'b0;
  logic            rst;
  logic [NIRQ-1:0] irq_req;
  logic            mem_busy, load_use, branch_taken, uret_ex;
  logic            pc_en, ifid_en, ifid_flush, idex_en, idex_flush, int_enter, in_handler;
  logic [IRSW-1:0] irs;
  logic [NIRQ-1:0] int_ack;

  pipe_int_ctrl #(.NUM_IRQ(NIRQ), .IRS_W(IRSW)) dut (
    .clk          (clk),
    .rst          (rst),
    .irq_req      (irq_req),
    .mem_busy     (mem_busy),
    .load_use     (load_use),
    .branch_taken (branch_taken),
    .uret_ex      (uret_ex),
    .pc_en        (pc_en),
    .ifid_en      (ifid_en),
    .ifid_flush   (ifid_flush),
    .idex_en      (idex_en),
    .idex_flush   (idex_flush),
    .int_enter    (int_enter),
    .irs          (irs),
    .int_ack      (int_ack),
    .in_handler   (in_handler)
  );

  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  // Behavioural model: pending set, entry-in-progress flag, in-service flag, active source number.
  logic [NIRQ-1:0] m_pend;
  logic [NIRQ-1:0] m_prev_req;
  bit              m_entering;
  bit              m_servicing;
  int              m_src;

  function automatic logic [VW-1:0] dut_vec();
    return {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, int_enter, irs, int_ack, in_handler};
  endfunction

  function automatic logic [VW-1:0] model_vec();
    logic pc, fe, ff, de, df, ent;
    logic [NIRQ-1:0] ack;
    pc = 1'b1; fe = 1'b1; ff = 1'b0; de = 1'b1; df = 1'b0; ent = 1'b0; ack = '0;
    if (mem_busy) begin
      pc = 1'b0; fe = 1'b0; de = 1'b0;
    end else if (m_entering) begin
      ff = 1'b1; ent = 1'b1; ack[m_src-1] = 1'b1;
    end else if (branch_taken) begin
      ff = 1'b1; df = 1'b1;
    end else if (load_use) begin
      pc = 1'b0; fe = 1'b0; df = 1'b1;
    end
    return {pc, fe, ff, de, df, ent, IRSW'(m_src), ack, 1'(m_servicing)};
  endfunction

  task automatic model_reset();
    m_pend = '0; m_prev_req = '0; m_entering = 0; m_servicing = 0; m_src = 0;
  endtask

  task automatic do_reset(input logic [NIRQ-1:0] req);
    @(negedge clk);
    rst = 1'b1; irq_req = req; mem_busy = 0; load_use = 0; branch_taken = 0; uret_ex = 0;
    model_reset();
    repeat (2) @(posedge clk);
  endtask

  // Drives one cycle of inputs, samples DUT and model outputs, then advances the model across the edge.
  task automatic run_cycle(input logic [NIRQ-1:0] req, input logic mb, input logic lu,
                           input logic bt, input logic ur,
                           output logic [VW-1:0] obs, output logic [VW-1:0] exp);
    logic [NIRQ-1:0] det, ack, n_pend;
    bit n_ent, n_srv;
    int n_src;
    @(negedge clk);
    rst = 1'b0; irq_req = req; mem_busy = mb; load_use = lu; branch_taken = bt; uret_ex = ur;
    #1;
    obs = dut_vec();
    exp = model_vec();
    ack = '0;
    if (!mb && m_entering) ack[m_src-1] = 1'b1;
`ifdef IRQ_EDGE_DETECT_EN
    det = req & ~m_prev_req;
`else
    det = req;
`endif
    n_pend = (m_pend & ~ack) | det;
    n_ent = m_entering; n_srv = m_servicing; n_src = m_src;
    if (!mb) begin
      if (m_entering) begin
        n_ent = 0; n_srv = 1;
      end else if (m_servicing) begin
        if (ur) begin n_srv = 0; n_src = 0; end
      end else if (m_pend != '0 && !lu && !bt) begin
        n_ent = 1;
        for (int i = NIRQ - 1; i >= 0; i--) if (m_pend[i]) n_src = i + 1;
      end
    end
    @(posedge clk);
    m_pend = n_pend; m_prev_req = req; m_entering = n_ent; m_servicing = n_srv; m_src = n_src;
  endtask

  task automatic test_reset();
    logic [VW-1:0] obs, exp, rst_vec;
    rst_vec = {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0};
    do_reset(3'b111);
    #1;
    obs = dut_vec();
    n_checks++;
    if (obs !== rst_vec) begin
      n_fail++; $display("FAIL reset_values: got %h expected %h", obs, rst_vec);
    end
    for (int c = 0; c < 3; c++) begin
      run_cycle(3'b111, 0, 0, 0, 0, obs, exp);
      n_checks++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL reset_release_c%0d: got %h expected %h", c, obs, exp);
      end
      if (c == 2) begin
        n_checks++;
        if (obs[P_ENT] !== 1'b1 || obs[6:4] !== 3'd1 || obs[3:1] !== 3'b001) begin
          n_fail++; $display("FAIL reset_first_enter: got ent=%b irs=%0d ack=%b expected ent=1 irs=1 ack=001",
                             obs[P_ENT], obs[6:4], obs[3:1]);
        end
      end
    end
  endtask

  task automatic test_priority();
    logic [VW-1:0] obs, exp;
    do_reset('0);
    for (int c = 0; c < 8; c++) begin
      run_cycle((c == 0) ? 3'b110 : 3'b000, 0, 0, 0, (c == 4), obs, exp);
      n_checks++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL priority_c%0d: got %h expected %h", c, obs, exp);
      end
      if (c == 2) begin
        n_checks++;
        if (obs[P_ENT] !== 1'b1 || obs[6:4] !== 3'd2 || obs[3:1] !== 3'b010) begin
          n_fail++; $display("FAIL priority_first: got ent=%b irs=%0d ack=%b expected ent=1 irs=2 ack=010",
                             obs[P_ENT], obs[6:4], obs[3:1]);
        end
      end
      if (c == 5) begin
        n_checks++;
        if (obs[P_ENT] !== 1'b0 || obs[6:4] !== 3'd0 || obs[0] !== 1'b0) begin
          n_fail++; $display("FAIL priority_gap: got ent=%b irs=%0d hdl=%b expected 0 0 0",
                             obs[P_ENT], obs[6:4], obs[0]);
        end
      end
      if (c == 6) begin
        n_checks++;
        if (obs[P_ENT] !== 1'b1 || obs[6:4] !== 3'd3 || obs[3:1] !== 3'b100) begin
          n_fail++; $display("FAIL priority_second: got ent=%b irs=%0d ack=%b expected ent=1 irs=3 ack=100",
                             obs[P_ENT], obs[6:4], obs[3:1]);
        end
      end
    end
  endtask

  task automatic test_load_use();
    logic [VW-1:0] obs, exp;
    do_reset('0);
    for (int c = 0; c < 2; c++) begin
      run_cycle('0, 0, (c == 0), 0, 0, obs, exp);
      n_checks++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL load_use_c%0d: got %h expected %h", c, obs, exp);
      end
      n_checks++;
      if (obs[P_PC] !== (c != 0) || obs[P_FE] !== (c != 0) || obs[P_DF] !== (c == 0)) begin
        n_fail++; $display("FAIL load_use_ctl_c%0d: got pc=%b ifid_en=%b idex_flush=%b", c,
                           obs[P_PC], obs[P_FE], obs[P_DF]);
      end
    end
  endtask

  task automatic test_branch_load();
    logic [VW-1:0] obs, exp;
    do_reset('0);
    for (int c = 0; c < 5; c++) begin
      run_cycle((c == 0) ? 3'b001 : 3'b000, 0, (c == 1), (c == 1), 0, obs, exp);
      n_checks++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL branch_load_c%0d: got %h expected %h", c, obs, exp);
      end
      if (c == 1) begin
        n_checks++;
        if (obs[P_FF] !== 1'b1 || obs[P_DF] !== 1'b1 || obs[P_PC] !== 1'b1 || obs[P_ENT] !== 1'b0) begin
          n_fail++; $display("FAIL branch_load_ctl: got ifid_flush=%b idex_flush=%b pc=%b ent=%b expected 1 1 1 0",
                             obs[P_FF], obs[P_DF], obs[P_PC], obs[P_ENT]);
        end
      end
      if (c == 2 || c == 3) begin
        n_checks++;
        if (obs[P_ENT] !== (c == 3)) begin
          n_fail++; $display("FAIL branch_defer_c%0d: got ent=%b expected %b", c, obs[P_ENT], (c == 3));
        end
      end
    end
  endtask

  task automatic test_mem_busy_enter();
    logic [VW-1:0] obs, exp;
    int n_ent;
    do_reset('0);
    n_ent = 0;
    for (int c = 0; c < 8; c++) begin
      run_cycle((c == 0) ? 3'b001 : 3'b000, (c >= 2 && c <= 4), 0, 0, 0, obs, exp);
      n_checks++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL mem_busy_c%0d: got %h expected %h", c, obs, exp);
      end
      if (c >= 2) n_ent += int'(obs[P_ENT]);
      if (c >= 2 && c <= 4) begin
        n_checks++;
        if (obs[P_PC] || obs[P_FE] || obs[P_DE] || obs[P_ENT] || obs[3:1] !== 3'b000 || obs[6:4] !== 3'd1) begin
          n_fail++; $display("FAIL mem_busy_hold_c%0d: got pc=%b ifid=%b idex=%b ent=%b ack=%b irs=%0d",
                             c, obs[P_PC], obs[P_FE], obs[P_DE], obs[P_ENT], obs[3:1], obs[6:4]);
        end
      end
      if (c == 5) begin
        n_checks++;
        if (obs[P_ENT] !== 1'b1 || obs[3:1] !== 3'b001) begin
          n_fail++; $display("FAIL mem_busy_release: got ent=%b ack=%b expected 1 001", obs[P_ENT], obs[3:1]);
        end
      end
    end
    n_checks++;
    if (n_ent != 1) begin
      n_fail++; $display("FAIL mem_busy_pulse_count: got %0d expected 1", n_ent);
    end
  endtask

  task automatic test_edge_level();
    logic [VW-1:0] obs, exp;
    int n_re, exp_re;
`ifdef IRQ_EDGE_DETECT_EN
    exp_re = 0;
`else
    exp_re = 1;
`endif
    do_reset('0);
    n_re = 0;
    for (int c = 0; c < 10; c++) begin
      run_cycle(3'b001, 0, 0, 0, (c == 4), obs, exp);
      n_checks++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL edge_level_c%0d: got %h expected %h", c, obs, exp);
      end
      if (c >= 5 && obs[P_ENT] === 1'b1) begin
        n_re++;
        n_checks++;
        if (obs[6:4] !== 3'd1) begin
          n_fail++; $display("FAIL edge_level_irs: got %0d expected 1", obs[6:4]);
        end
      end
    end
    n_checks++;
    if (n_re != exp_re) begin
      n_fail++; $display("FAIL edge_level_reentry: got %0d expected %0d", n_re, exp_re);
    end
  endtask

  task automatic test_reset_mid();
    logic [VW-1:0] obs, exp;
    do_reset('0);
    for (int c = 0; c < 2; c++) run_cycle((c == 0) ? 3'b010 : 3'b000, 0, 0, 0, 0, obs, exp);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (int_enter !== 1'b0 || irs !== 3'd0 || int_ack !== 3'b000) begin
      n_fail++; $display("FAIL reset_mid_enter: got ent=%b irs=%0d ack=%b expected 0 0 000", int_enter, irs, int_ack);
    end
    do_reset('0);
    for (int c = 0; c < 3; c++) run_cycle((c == 0) ? 3'b100 : 3'b000, 0, 0, 0, 0, obs, exp);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (in_handler !== 1'b0 || irs !== 3'd0) begin
      n_fail++; $display("FAIL reset_mid_handler: got hdl=%b irs=%0d expected 0 0", in_handler, irs);
    end
    do_reset('0);
    for (int c = 0; c < 3; c++) begin
      run_cycle('0, 0, 0, 0, 0, obs, exp);
      n_checks++;
      if (obs !== exp || obs[P_ENT] !== 1'b0) begin
        n_fail++; $display("FAIL reset_mid_cleared_c%0d: got %h expected %h", c, obs, exp);
      end
    end
  endtask

  task automatic test_random();
    logic [VW-1:0] obs, exp;
    logic [NIRQ-1:0] req;
    do_reset('0);
    for (int c = 0; c < 600; c++) begin
      req = ($urandom_range(0, 99) < 25) ? NIRQ'($urandom_range(1, 7)) : '0;
      run_cycle(req, ($urandom_range(0, 99) < 12), ($urandom_range(0, 99) < 15),
                ($urandom_range(0, 99) < 10), ($urandom_range(0, 99) < 20), obs, exp);
      n_checks++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL random_c%0d: got %h expected %h", c, obs, exp);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; irq_req = '0; mem_busy = 0; load_use = 0; branch_taken = 0; uret_ex = 0;
    model_reset();
    test_reset();
    test_priority();
    test_load_use();
    test_branch_load();
    test_mem_busy_enter();
    test_edge_level();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
